// File: rtl/adc124_spi_ctrl_if.sv
// Control, result and serial-pin bundle between the ADC124S021 sequencer and its
// surroundings (register bank on the control/result side, converter on the pins).
interface adc124_spi_ctrl_if;
  logic        start;
  logic        continuous;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [11:0] res_data;
  logic        scan_done;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_din;
  logic        adc_dout;

  modport master (
    output start, continuous, adc_dout,
    input  busy, res_valid, res_ch, res_data, scan_done, adc_cs_n, adc_sclk, adc_din
  );

  modport slave (
    input  start, continuous, adc_dout,
    output busy, res_valid, res_ch, res_data, scan_done, adc_cs_n, adc_sclk, adc_din
  );
endinterface

// File: rtl/adc124_spi_ctrl.sv
// SPI sequencer for the ADC124S021: runs 5-frame, 4-channel scans and
// returns each 12-bit result as a single-cycle valid pulse.
module adc124_spi_ctrl #(
  parameter int unsigned SCLK_HALF = 4,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic               clock,
  input  logic               reset,
  adc124_spi_ctrl_if.slave   bus
);

  localparam int unsigned CNT_MAX = (SCLK_HALF > CS_GAP) ? SCLK_HALF : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HALF_RLD = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_RLD  = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [2:0] LAST_FRAME = 3'd4;

  // Frame f addresses channel f; the trailing fifth frame re-addresses channel 0.
  function automatic logic [15:0] ctrl_word(input logic [2:0] f);
    logic [1:0] addr;
    addr = (f <= 3'd3) ? f[1:0] : 2'd0;
    return {3'b000, addr, 11'b0};
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [2:0]       frame_q, frame_d;
  logic [11:0]      shift_q, shift_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       res_ch_q, res_ch_d;
  logic [11:0]      res_data_q, res_data_d;
  logic             scan_done_q, scan_done_d;

  logic [15:0]      ctrl_c;
  logic [3:0]       nbit_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    shift_d     = shift_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    din_d       = din_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    scan_done_d = 1'b0;
    ctrl_c      = ctrl_word(frame_q);
    nbit_c      = bit_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SETUP;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          cnt_d   = HALF_RLD;
          frame_d = 3'd0;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b0;
          bit_d   = 4'd0;
          din_d   = ctrl_c[15];
          cnt_d   = HALF_RLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!sclk_q) begin
          // Only the low 12 bits are ever reported, so older bits fall off the top.
          sclk_d  = 1'b1;
          shift_d = {shift_q[10:0], bus.adc_dout};
          cnt_d   = HALF_RLD;
        end else if (bit_q == 4'd15) begin
          state_d = S_NEXT;
          if (frame_q != 3'd0) begin
            res_valid_d = 1'b1;
            res_ch_d    = 2'(frame_q - 3'd1);
            res_data_d  = shift_q;
          end
        end else begin
          sclk_d = 1'b0;
          bit_d  = nbit_c;
          din_d  = ctrl_c[4'd15 - nbit_c];
          cnt_d  = HALF_RLD;
        end
      end

      S_NEXT: begin
        if (frame_q != LAST_FRAME) begin
          // cs_n stays low: next frame starts straight away; control MSB is always 0.
          state_d = S_SHIFT;
          frame_d = frame_q + 3'd1;
          sclk_d  = 1'b0;
          bit_d   = 4'd0;
          din_d   = 1'b0;
          cnt_d   = HALF_RLD;
        end else begin
          state_d     = S_HOLD;
          scan_done_d = 1'b1;
          cs_n_d      = 1'b1;
          din_d       = 1'b0;
          cnt_d       = GAP_RLD;
        end
      end

      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (bus.continuous) begin
          state_d = S_SETUP;
          frame_d = 3'd0;
          cs_n_d  = 1'b0;
          cnt_d   = HALF_RLD;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        din_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      frame_q     <= 3'd0;
      shift_q     <= 12'd0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= 2'd0;
      res_data_q  <= 12'd0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      shift_q     <= shift_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_data  = res_data_q;
  assign bus.scan_done = scan_done_q;
  assign bus.adc_cs_n  = cs_n_q;
  assign bus.adc_sclk  = sclk_q;
  assign bus.adc_din   = din_q;

endmodule

// File: doc/adc124_spi_ctrl.md
# adc124_spi_ctrl

SPI sequencer for the ADC124S021 4-channel 12-bit converter behind the axi_l_adc124 peripheral. It sits directly downstream of the AXI-Lite register bank and consumes that bank's start/continuous controls. It drives the converter's serial pins, runs one 4-channel scan per request, and returns each 12-bit result as a single-cycle valid pulse that the register bank latches into its per-channel data registers.

## Interface
- SCLK_HALF, 4: clock cycles per SCLK half-period; legal range is 2 to 255.
- CS_GAP, 4: clock cycles adc_cs_n is held high between scans; minimum 1.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle scan request; ignored while busy=1.
- continuous  in  1  level; while high, scans repeat back-to-back.
- busy  out  1  high from the cycle after an accepted start until the end of the CS_GAP hold.
- res_valid  out  1  single-cycle pulse, one per channel result.
- res_ch  out  2  channel index of res_data; valid with res_valid.
- res_data  out  12  conversion result; valid with res_valid.
- scan_done  out  1  single-cycle pulse one cycle after the channel-3 res_valid.
- adc_cs_n  out  1  converter chip select, active low.
- adc_sclk  out  1  serial clock; idles high.
- adc_din  out  1  control word to the converter; idles 0.
- adc_dout  in  1  converter data output; the block treats it as already synchronous.

## Operation
- FSM states: IDLE, SETUP, SHIFT, NEXT, HOLD.
- IDLE:
  - Outputs: cs_n=1, sclk=1, din=0, busy=0.
  - start=1 → SETUP. Frame counter f=0.
- SETUP:
  - cs_n=0, busy=1.
  - Wait SCLK_HALF cycles → SHIFT.
- SHIFT: 16 bits, bit index b=0..15. Each bit is SCLK_HALF cycles low followed by SCLK_HALF cycles high.
  - Falling sclk: din is updated to ctrl[15-b].
  - ctrl = {3'b000, addr[1:0], 11'b0}, with addr = f for f≤3 and 0 for f=4.
  - Rising sclk: adc_dout is shifted into a 16-bit shift register, MSB first.
  - After the 16th high phase → NEXT.
- NEXT: 1 cycle, during which sclk stays high.
  - If f≥1: res_valid=1, res_ch=f-1, res_data=shift[11:0]. shift[15:12] is discarded.
  - If f<4: f++ and go to SHIFT with cs_n still low (continuous-frame mode).
  - If f=4: scan_done is pulsed on the following cycle, then → HOLD.
- Frame numbering: the converter returns the channel addressed in the previous frame. Frame 0's result is therefore discarded, and each scan is 5 frames.
- HOLD:
  - cs_n=1, sclk=1, din=0.
  - Wait CS_GAP cycles.
  - Then: continuous=1 → SETUP with f=0, busy stays 1. Otherwise → IDLE.
- Control sampling:
  - continuous is sampled only at the end of HOLD. Deasserting it mid-scan lets the current scan finish.
  - start while busy=1, or in the same cycle as a HOLD→SETUP restart, is dropped; it is not queued.
- Reset, effective on the next edge from any state:
  - State → IDLE.
  - cs_n=1, sclk=1, din=0.
  - busy=0, res_valid=0, scan_done=0, res_ch=0, res_data=0, f=0.
  - A partial scan emits no further results.

## Timing
- start accepted at cycle 0: busy=1 and cs_n=0 at cycle 1.
- First sclk falling edge at cycle 1+SCLK_HALF.
- Frame length: 32·SCLK_HALF cycles of SHIFT plus 1 NEXT cycle.
- With SCLK_HALF=4, one frame is 129 cycles:
  - The f=1 result (ch0) is valid at cycle 1+4+2·129−1 = 262.
  - Channel k is valid at 262+129·k.
  - scan_done at cycle 650.
  - busy falls at 650+CS_GAP.
- The adc_dout sample is taken on the clock edge where sclk goes 0→1, from the value present during the preceding low phase.
- din changes only on the edge where sclk goes 1→0, or on entry to SHIFT.
- res_valid and scan_done are registered outputs and never span more than 1 cycle.
- res_ch and res_data hold their last value between pulses.

## Test plan
- Reset defaults: assert reset mid-SHIFT → next cycle cs_n=1, sclk=1, busy=0. No res_valid occurs for 1000 cycles afterwards.
- Single scan: converter model returns 0x0A5, 0x5A0, 0xFFF, 0x001 for ch0..ch3 → four res_valid pulses with res_ch 0,1,2,3 and matching data, then one scan_done, with cycle counts as in Timing (SCLK_HALF=4).
- Address encoding: check that din bits 12:11 across the 5 frames are 00, 01, 10, 11, 00, and every other din bit is 0.
- Leading bits ignored: model drives 0xF123 on a channel → res_data=0x123.
- Continuous mode: continuous=1 → the second scan's SETUP starts exactly CS_GAP cycles after the first HOLD begins, and busy never drops. Drop continuous mid-scan → that scan completes, then IDLE.
- Start while busy: pulse start at cycle 100 of a scan → exactly 4 results and 1 scan_done in total.
